// File: rtl/mmio_responder.sv
// Memory-mapped peripheral with a 16-word window: byte TX FIFO, free-running timer with compare, and a level irq.
// Reads return pre-edge state one cycle after the address is sampled.
module mmio_responder #(
    parameter logic [11:0] BASE  = 12'hFF0,
    parameter int          DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q,
    output logic        hit,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        irq
);
    localparam int         PW       = $clog2(DEPTH);
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);

    localparam logic [3:0] OFF_STATUS  = 4'd0;
    localparam logic [3:0] OFF_TXDATA  = 4'd1;
    localparam logic [3:0] OFF_TIMER   = 4'd2;
    localparam logic [3:0] OFF_COMPARE = 4'd3;
    localparam logic [3:0] OFF_CTRL    = 4'd4;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [4:0]    count;
    logic [31:0]   timer, compare;
    logic          irq_en, timer_en;
    logic          match, overflow;

    logic        win, wr, fifo_empty, fifo_full;
    logic        pop, push_req, push, ovf_set, match_set;
    logic        wr_timer, wr_compare, wr_ctrl;
    logic [3:0]  off;
    logic [31:0] rdata;

    assign win        = (address[11:4] == BASE[11:4]);
    assign off        = address[3:0];
    assign wr         = wren && win;
    assign fifo_empty = (count == 5'd0);
    assign fifo_full  = (count == FULL_CNT);

    assign pop        = !fifo_empty && out_ready;
    assign push_req   = wr && (off == OFF_TXDATA);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign match_set  = timer_en && (timer == compare);
    assign wr_timer   = wr && (off == OFF_TIMER);
    assign wr_compare = wr && (off == OFF_COMPARE);
    assign wr_ctrl    = wr && (off == OFF_CTRL);

    assign out_valid  = !fifo_empty;
    assign out_data   = mem[rptr];
    assign irq        = match && irq_en;

    always_comb begin
        rdata = '0;
        if (win) begin
            case (off)
                OFF_STATUS:  rdata = {22'b0, overflow, match, 1'b0, count, fifo_full, fifo_empty};
                OFF_TIMER:   rdata = timer;
                OFF_COMPARE: rdata = compare;
                OFF_CTRL:    rdata = {30'b0, timer_en, irq_en};
                default:     rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            timer    <= '0;
            compare  <= '1;
            irq_en   <= 1'b0;
            timer_en <= 1'b0;
            match    <= 1'b0;
            overflow <= 1'b0;
            q        <= '0;
            hit      <= 1'b0;
        end else begin
            q   <= rdata;
            hit <= win;

            if (push) begin
                mem[wptr] <= data[7:0];
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 5'd1;
            else if (pop && !push) count <= count - 5'd1;

            if (wr_timer)      timer <= data;
            else if (timer_en) timer <= timer + 32'd1;

            if (wr_compare) compare <= data;

            if (wr_ctrl) begin
                irq_en   <= data[0];
                timer_en <= data[1];
            end

            // Set beats a same-edge write-one-to-clear.
            if (match_set)                match <= 1'b1;
            else if (wr_ctrl && data[8])  match <= 1'b0;

            if (ovf_set)                  overflow <= 1'b1;
            else if (wr_ctrl && data[9])  overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register reads, FIFO flow/overflow, timer/compare irq, async reset.
module tb_mmio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address = 12'h100;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q;
    logic        hit;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        irq;

    int total = 0;
    int bad   = 0;

    mmio_responder #(.BASE(12'hFF0), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren),
        .q(q), .hit(hit), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wren    = 1'b0;
        address = 12'h100;
        data    = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        address = a;
        data    = d;
        wren    = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [11:0] a);
        address = a;
        wren    = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        #12;
        total++; if (q !== 32'h0) begin bad++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_window();
        rd(12'hFF0);
        total++; if (q !== 32'h00000001) begin bad++; $display("FAIL status_read got=%h exp=%h", q, 32'h1); end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL status_hit got=%b exp=1", hit); end
        rd(12'h100);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL outside_q got=%h exp=0", q); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL outside_hit got=%b exp=0", hit); end
        rd(12'hFF3);
        total++; if (q !== 32'hFFFFFFFF) begin bad++; $display("FAIL compare_reset got=%h exp=ffffffff", q); end
        rd(12'hFF7);
        total++; if (q !== 32'h0 || hit !== 1'b1) begin bad++; $display("FAIL unmapped_off q=%h hit=%b exp q=0 hit=1", q, hit); end
        // Writes outside the window or to unmapped offsets must not push.
        wr(12'hEF1, 32'h99);
        wr(12'hFF5, 32'h98);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ignored_write out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(12'hFF1, 32'h41 + i);
        rd(12'hFF0);
        total++; if (q !== 32'h00000212) begin bad++; $display("FAIL full_status got=%h exp=%h", q, 32'h212); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h41 + i)) begin
                bad++; $display("FAIL drain_%0d valid=%b data=%h exp data=%h", i, out_valid, out_data, 8'(8'h41 + i));
            end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
        wr(12'hFF4, 32'h200);
        rd(12'hFF0);
        total++; if (q !== 32'h00000001) begin bad++; $display("FAIL ovf_clear got=%h exp=1", q); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(12'hFF1, i);
        out_ready = 1'b1;
        wr(12'hFF1, 32'h55);
        out_ready = 1'b0;
        rd(12'hFF0);
        total++; if (q !== 32'h00000012) begin bad++; $display("FAIL full_pushpop_status got=%h exp=%h", q, 32'h12); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp;
            exp = (i == 3) ? 8'h55 : 8'(i + 2);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                bad++; $display("FAIL pushpop_order_%0d valid=%b data=%h exp=%h", i, out_valid, out_data, exp);
            end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushpop_empty out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_pre out_valid=%b exp=0", out_valid); end
        address = 12'hFF1;
        wren    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = 32'h70 + i;
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h70 + i)) begin
                bad++; $display("FAIL b2b_%0d valid=%b data=%h exp=%h", i, out_valid, out_data, 8'(8'h70 + i));
            end
        end
        idle();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_timer();
        wr(12'hFF2, 32'hFFFFFFFE);
        wr(12'hFF4, 32'h3);
        wr(12'hFF3, 32'h1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL timer_irq_early got=%b exp=0", irq); end
        tick();
        rd(12'hFF2);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL timer_wrap got=%h exp=0", q); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL timer_irq_at0 got=%b exp=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL timer_irq_match got=%b exp=1", irq); end
        rd(12'hFF0);
        total++; if (q !== 32'h00000101) begin bad++; $display("FAIL match_status got=%h exp=%h", q, 32'h101); end
        wr(12'hFF4, 32'h103);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
        rd(12'hFF4);
        total++; if (q !== 32'h3) begin bad++; $display("FAIL ctrl_read got=%h exp=3", q); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(12'hFF1, 32'hA0 + i);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset out_valid=%b exp=1", out_valid); end
        #2 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset out_valid=%b exp=0", out_valid); end
        @(negedge clock);
        reset = 1'b1;
        rd(12'hFF0);
        total++; if (q !== 32'h00000001) begin bad++; $display("FAIL post_reset_status got=%h exp=1", q); end
        rd(12'hFF2);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL post_reset_timer got=%h exp=0", q); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL post_reset_irq got=%b exp=0", irq); end
    endtask

    initial begin
        test_reset();
        test_window();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_timer();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
